// File: rtl/crc_serial_engine_if.sv
// Bit-serial CRC engine bus: framed serial input on one side, FCS stream
// and frame status on the other. The master drives the frame bits and the
// slave (the engine) drives status and FCS back.
interface crc_serial_engine_if #(
  parameter int WIDTH = 16
) ();
  logic             data;
  logic             data_valid;
  logic             sof;
  logic             eof;
  logic             check_mode;
  logic             busy;
  logic             fcs_bit;
  logic             fcs_valid;
  logic [WIDTH-1:0] fcs_reg;
  logic             done;
  logic             crc_ok;
  logic             crc_err;

  modport master (
    output data, data_valid, sof, eof, check_mode,
    input  busy, fcs_bit, fcs_valid, fcs_reg, done, crc_ok, crc_err
  );

  modport slave (
    input  data, data_valid, sof, eof, check_mode,
    output busy, fcs_bit, fcs_valid, fcs_reg, done, crc_ok, crc_err
  );
endinterface

// File: rtl/crc_serial_engine.sv
// Parametrised bit-serial CRC engine. Absorbs a framed LSB-first bit stream
// and either appends the FCS serially (generate mode) or compares the final
// register against a residue (check mode). All outputs are registered.
module crc_serial_engine #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = 16'h8408,
  parameter logic [WIDTH-1:0] INIT    = 16'h0000,
  parameter logic [WIDTH-1:0] XOR_OUT = 16'h0000,
  parameter logic [WIDTH-1:0] RESIDUE = 16'h0000
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  crc_serial_engine_if.slave   bus
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SHIFT, S_RESULT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] fcs_reg_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             busy_q;
  logic             fcs_bit_q;
  logic             fcs_valid_q;
  logic             done_q;
  logic             ok_q;
  logic             err_q;

  logic             accept_d;
  logic             mode_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] final_d;

  // One reflected CRC step for a single input bit.
  function automatic logic [WIDTH-1:0] crc_update(input logic [WIDTH-1:0] r,
                                                  input logic             d);
    crc_update = (r >> 1) ^ ((d ^ r[0]) ? POLY : '0);
  endfunction

  // Decide whether this bit is taken and what the register becomes; a sof
  // restarts from INIT whether we are idle or mid-frame.
  always_comb begin
    accept_d = 1'b0;
    case (state_q)
      S_IDLE:  accept_d = bus.data_valid & bus.sof;
      S_ACCUM: accept_d = bus.data_valid;
      default: accept_d = 1'b0;
    endcase
    mode_d  = bus.sof ? bus.check_mode : mode_q;
    r_d     = crc_update(bus.sof ? INIT : r_q, bus.data);
    final_d = r_d ^ XOR_OUT;
  end

  // Frame FSM with registered outputs. cnt_q counts FCS bits already put on
  // fcs_bit, so bit 0 is presented in the cycle right after eof.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      r_q         <= INIT;
      shreg_q     <= '0;
      fcs_reg_q   <= INIT;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      busy_q      <= 1'b0;
      fcs_bit_q   <= 1'b0;
      fcs_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept_d) begin
            r_q       <= r_d;
            mode_q    <= mode_d;
            fcs_reg_q <= r_d;
            if (bus.sof) begin
              ok_q  <= 1'b0;
              err_q <= 1'b0;
            end
            if (bus.eof) begin
              fcs_reg_q <= final_d;
              busy_q    <= 1'b1;
              if (mode_d) begin
                ok_q    <= (r_d == RESIDUE);
                err_q   <= (r_d != RESIDUE);
                done_q  <= 1'b1;
                state_q <= S_RESULT;
              end else begin
                shreg_q     <= final_d >> 1;
                fcs_bit_q   <= final_d[0];
                fcs_valid_q <= 1'b1;
                cnt_q       <= CW'(1);
                state_q     <= S_SHIFT;
              end
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            fcs_bit_q   <= 1'b0;
            fcs_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            fcs_bit_q <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        S_RESULT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.fcs_bit   = fcs_bit_q;
  assign bus.fcs_valid = fcs_valid_q;
  assign bus.fcs_reg   = fcs_reg_q;
  assign bus.done      = done_q;
  assign bus.crc_ok    = ok_q;
  assign bus.crc_err   = err_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: a CRC-16/KERMIT instance and an X.25
// instance share one stimulus stream and are checked against hand values.
module tb_crc_serial_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data = 1'b0;
  logic dv = 1'b0;
  logic sof = 1'b0;
  logic eof = 1'b0;
  logic cm = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  payload [9];
  logic [15:0] exp_k = 16'h2189;
  logic [15:0] exp_x = 16'h906E;

  always #5 clk = ~clk;

  crc_serial_engine_if #(.WIDTH(16)) bk ();
  crc_serial_engine_if #(.WIDTH(16)) bx ();

  assign bk.data = data;  assign bk.data_valid = dv;  assign bk.sof = sof;
  assign bk.eof  = eof;   assign bk.check_mode = cm;
  assign bx.data = data;  assign bx.data_valid = dv;  assign bx.sof = sof;
  assign bx.eof  = eof;   assign bx.check_mode = cm;

  crc_serial_engine #(.WIDTH(16)) u_kermit (
    .clock_i(clk), .reset_n_i(rst_n), .bus(bk)
  );

  crc_serial_engine #(
    .WIDTH(16), .POLY(16'h8408), .INIT(16'hFFFF),
    .XOR_OUT(16'hFFFF), .RESIDUE(16'hF0B8)
  ) u_x25 (
    .clock_i(clk), .reset_n_i(rst_n), .bus(bx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends the 9-byte payload (optionally a bit flipped, optionally 16 FCS bits
  // appended), LSB first. Returns in the cycle right after the eof edge.
  task automatic send_frame(input logic [15:0] app, input bit cmode, input bit append,
                            input int flip, input bit gaps, input bit restart);
    int n;
    logic [7:0] byt;
    n  = append ? 88 : 72;
    cm = cmode;
    if (restart) begin
      for (int g = 0; g < 3; g++) begin
        dv = 1'b1; sof = (g == 0); eof = 1'b0; data = (g != 2);
        tick();
      end
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 7 == 3)) begin
        dv = 1'b0; sof = 1'b0; eof = 1'b0; data = 1'b1;
        tick();
      end
      if (i < 72) begin
        byt  = payload[i / 8];
        data = byt[i % 8] ^ (i == flip);
      end else begin
        data = app[i - 72];
      end
      dv = 1'b1; sof = (i == 0); eof = (i == n - 1);
      tick();
      if (i == 0) begin
        chk("first_bit_kermit", bk.fcs_reg, 16'h8408);
        chk("first_bit_x25", bx.fcs_reg, 16'h7FFF);
      end
    end
    dv = 1'b0; sof = 1'b0; eof = 1'b0; data = 1'b0;
  endtask

  // Follows the 16 FCS bits of a generate frame on both instances, then the
  // done pulse. Optionally pokes sof during the shift or resets at bit reset_at.
  task automatic gen_stream(input string tag, input bit inject_sof, input int reset_at);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_valid"}, bk.fcs_valid, 1);
      chk({tag, "_busy"}, bk.busy, 1);
      chk({tag, "_bit_kermit"}, bk.fcs_bit, exp_k[k]);
      chk({tag, "_bit_x25"}, bx.fcs_bit, exp_x[k]);
      if (k == reset_at) begin
        rst_n = 1'b0; dv = 1'b0; sof = 1'b0; data = 1'b0;
        tick();
        chk({tag, "_rst_valid"}, bk.fcs_valid, 0);
        chk({tag, "_rst_done"}, bk.done, 0);
        chk({tag, "_rst_busy"}, bk.busy, 0);
        chk({tag, "_rst_reg_kermit"}, bk.fcs_reg, 16'h0000);
        chk({tag, "_rst_reg_x25"}, bx.fcs_reg, 16'hFFFF);
        rst_n = 1'b1;
        return;
      end
      if (inject_sof && k == 3) begin
        dv = 1'b1; sof = 1'b1; data = 1'b1;
      end else begin
        dv = 1'b0; sof = 1'b0; data = 1'b0;
      end
      tick();
    end
    dv = 1'b0; sof = 1'b0; data = 1'b0;
    chk({tag, "_done"}, bk.done, 1);
    chk({tag, "_end_valid"}, bk.fcs_valid, 0);
    chk({tag, "_end_busy"}, bk.busy, 0);
    chk({tag, "_end_bit"}, bk.fcs_bit, 0);
    chk({tag, "_reg_kermit"}, bk.fcs_reg, 16'h2189);
    chk({tag, "_reg_x25"}, bx.fcs_reg, 16'h906E);
    tick();
    chk({tag, "_done_pulse"}, bk.done, 0);
  endtask

  initial begin
    for (int b = 0; b < 9; b++) payload[b] = 8'h31 + 8'(b);

    // Reset values
    tick(); tick();
    chk("rst_busy", bk.busy, 0);
    chk("rst_valid", bk.fcs_valid, 0);
    chk("rst_bit", bk.fcs_bit, 0);
    chk("rst_done", bk.done, 0);
    chk("rst_ok", bk.crc_ok, 0);
    chk("rst_err", bk.crc_err, 0);
    chk("rst_reg_kermit", bk.fcs_reg, 16'h0000);
    chk("rst_reg_x25", bx.fcs_reg, 16'hFFFF);
    rst_n = 1'b1;
    tick();

    // Generate, contiguous
    send_frame(16'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    gen_stream("gen", 1'b0, -1);

    // Generate with gaps and a sof restart after garbage
    send_frame(16'h0, 1'b0, 1'b0, -1, 1'b1, 1'b1);
    gen_stream("gap", 1'b0, -1);

    // Check mode, KERMIT FCS appended
    send_frame(16'h2189, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("chk_done", bk.done, 1);
    chk("chk_busy", bk.busy, 1);
    chk("chk_ok", bk.crc_ok, 1);
    chk("chk_err", bk.crc_err, 0);
    chk("chk_valid", bk.fcs_valid, 0);
    chk("chk_reg", bk.fcs_reg, 16'h0000);
    tick();
    chk("chk_done_pulse", bk.done, 0);
    chk("chk_busy_after", bk.busy, 0);
    chk("chk_ok_held", bk.crc_ok, 1);

    // Check mode with one payload bit flipped
    send_frame(16'h2189, 1'b1, 1'b1, 10, 1'b0, 1'b0);
    chk("flip_err", bk.crc_err, 1);
    chk("flip_ok", bk.crc_ok, 0);
    chk("flip_done", bk.done, 1);
    tick();

    // Check mode, X.25 FCS appended
    send_frame(16'h906E, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("x25_ok", bx.crc_ok, 1);
    chk("x25_err", bx.crc_err, 0);
    chk("x25_reg", bx.fcs_reg, 16'h0F47);
    tick();

    // Reset at the 5th FCS bit, then a clean frame
    send_frame(16'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    gen_stream("rst", 1'b0, 4);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_no_done", bk.done, 0);
      chk("rst_no_valid", bk.fcs_valid, 0);
    end
    send_frame(16'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    gen_stream("after_rst", 1'b0, -1);

    // sof during SHIFT is ignored
    send_frame(16'h0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    gen_stream("sofshift", 1'b1, -1);

    // data_valid without sof in IDLE is ignored
    dv = 1'b1; data = 1'b1; sof = 1'b0; eof = 1'b0;
    tick();
    dv = 1'b0; data = 1'b0;
    chk("idle_ignore_reg", bk.fcs_reg, 16'h2189);
    chk("idle_ignore_busy", bk.busy, 0);

    // One-bit frame
    dv = 1'b1; sof = 1'b1; eof = 1'b1; data = 1'b1; cm = 1'b0;
    tick();
    dv = 1'b0; sof = 1'b0; eof = 1'b0; data = 1'b0;
    chk("onebit_valid", bk.fcs_valid, 1);
    chk("onebit_reg", bk.fcs_reg, 16'h8408);
    chk("onebit_bit0", bk.fcs_bit, 0);
    for (int c = 0; c < 16; c++) tick();
    chk("onebit_done", bk.done, 1);
    chk("onebit_end_valid", bk.fcs_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
